// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared slot state, time type and time arithmetic for multi_alarm_clock
package clock_pkg;

  localparam int HOURS_MAX  = 23;
  localparam int MINSEC_MAX = 59;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_RINGING  = 2'd1,
    SLOT_SNOOZED  = 2'd2
  } slot_state_t;

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
  } clock_time_t;

  function automatic logic time_valid(input clock_time_t t);
    return (t.h <= 5'(HOURS_MAX)) && (t.m <= 6'(MINSEC_MAX)) && (t.s <= 6'(MINSEC_MAX));
  endfunction

  function automatic clock_time_t time_next_second(input clock_time_t t);
    clock_time_t r;
    r = t;
    if (t.s != 6'(MINSEC_MAX)) begin
      r.s = t.s + 6'd1;
    end else begin
      r.s = 6'd0;
      if (t.m != 6'(MINSEC_MAX)) begin
        r.m = t.m + 6'd1;
      end else begin
        r.m = 6'd0;
        r.h = (t.h == 5'(HOURS_MAX)) ? 5'd0 : t.h + 5'd1;
      end
    end
    return r;
  endfunction

  // mins is at most 59, so at most one hour carry is possible
  function automatic clock_time_t time_add_minutes(input clock_time_t t, input logic [5:0] mins);
    clock_time_t r;
    logic [6:0]  m_sum;
    r     = t;
    m_sum = {1'b0, t.m} + {1'b0, mins};
    if (m_sum > 7'(MINSEC_MAX)) begin
      r.m = 6'(m_sum - 7'd60);
      r.h = (t.h == 5'(HOURS_MAX)) ? 5'd0 : t.h + 5'd1;
    end else begin
      r.m = m_sum[5:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/alarm_slot.sv
// rtl/alarm_slot.sv - one alarm slot: stored time, enable, IDLE/RINGING/SNOOZED FSM, ring timeout
// MULTI_ALARM_SNOOZE_EN adds the snooze input, SNOOZED state and snooze target register.
module alarm_slot
  import clock_pkg::*;
#(
  parameter int RING_SEC   = 60
`ifdef MULTI_ALARM_SNOOZE_EN
  ,
  parameter int SNOOZE_MIN = 5
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr,
  input  clock_time_t wr_time,
  input  logic        wr_en,
  input  clock_time_t cur_time,
  input  logic        time_changed,
  input  logic        tick,
  input  logic        ack,
`ifdef MULTI_ALARM_SNOOZE_EN
  input  logic        snooze,
`endif
  output logic        ringing
);

  localparam int RW = $clog2(RING_SEC + 1);

  clock_time_t   alarm_time;
  logic          enabled;
  slot_state_t   state;
  logic [RW-1:0] ring_cnt;
  logic          match_alarm;

`ifdef MULTI_ALARM_SNOOZE_EN
  clock_time_t   snooze_time;
  logic          match_snooze;
  assign match_snooze = time_changed && (cur_time == snooze_time);
`endif

  // Matching only right after a time change keeps a held time from re-triggering
  assign match_alarm = time_changed && (cur_time == alarm_time);
  assign ringing     = (state == SLOT_RINGING);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alarm_time  <= '0;
      enabled     <= 1'b0;
      state       <= SLOT_IDLE;
      ring_cnt    <= '0;
`ifdef MULTI_ALARM_SNOOZE_EN
      snooze_time <= '0;
`endif
    end else if (wr) begin
      alarm_time <= wr_time;
      enabled    <= wr_en;
      state      <= SLOT_IDLE;
      ring_cnt   <= '0;
    end else begin
      case (state)
        SLOT_IDLE: begin
          if (enabled && match_alarm) begin
            state    <= SLOT_RINGING;
            ring_cnt <= RW'(RING_SEC);
          end
        end
        SLOT_RINGING: begin
          if (ack) begin
            state <= SLOT_IDLE;
`ifdef MULTI_ALARM_SNOOZE_EN
          end else if (snooze) begin
            state       <= SLOT_SNOOZED;
            snooze_time <= time_add_minutes(cur_time, 6'(SNOOZE_MIN));
`endif
          end else if (tick) begin
            if (ring_cnt <= RW'(1)) state <= SLOT_IDLE;
            else ring_cnt <= ring_cnt - RW'(1);
          end
        end
`ifdef MULTI_ALARM_SNOOZE_EN
        SLOT_SNOOZED: begin
          if (ack) begin
            state <= SLOT_IDLE;
          end else if (match_snooze) begin
            state    <= SLOT_RINGING;
            ring_cnt <= RW'(RING_SEC);
          end
        end
`endif
        default: state <= SLOT_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// rtl/multi_alarm_clock.sv - 24h clock with prescaler and NUM_ALARMS alarm slots
// MULTI_ALARM_SNOOZE_EN enables the snooze input; otherwise snooze is ignored.
module multi_alarm_clock
  import clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 4,
  parameter int NUM_ALARMS  = 4,
  parameter int SNOOZE_MIN  = 5,
  parameter int RING_SEC    = 60
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  set_time,
  input  logic                                                  set_alarm,
  input  logic [(NUM_ALARMS > 1 ? $clog2(NUM_ALARMS) : 1)-1:0]  alarm_sel,
  input  logic                                                  alarm_en,
  input  logic [4:0]                                            hours,
  input  logic [5:0]                                            minutes,
  input  logic [5:0]                                            seconds,
  input  logic                                                  ack,
  input  logic                                                  snooze,
  output logic [4:0]                                            cur_hours,
  output logic [5:0]                                            cur_minutes,
  output logic [5:0]                                            cur_seconds,
  output logic                                                  tick,
  output logic [NUM_ALARMS-1:0]                                 ringing,
  output logic                                                  alarm
);

  localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int PW    = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;

  logic [PW-1:0] presc;
  clock_time_t   cur_time;
  clock_time_t   load_time;
  logic          load_ok;
  logic          alarm_ok;
  logic          time_changed;

`ifndef MULTI_ALARM_SNOOZE_EN
  localparam int SNOOZE_MIN_UNUSED = SNOOZE_MIN;
  logic snooze_unused;
  assign snooze_unused = snooze;
`endif

  assign load_time = {hours, minutes, seconds};
  assign alarm_ok  = time_valid(load_time);
  assign load_ok   = set_time && alarm_ok;
  assign tick      = (presc == PW'(CLK_PER_SEC - 1));

  assign cur_hours   = cur_time.h;
  assign cur_minutes = cur_time.m;
  assign cur_seconds = cur_time.s;
  assign alarm       = |ringing;

  // A valid load wins over a coincident tick: prescaler restarts, no increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc        <= '0;
      cur_time     <= '0;
      time_changed <= 1'b0;
    end else begin
      time_changed <= load_ok || tick;
      if (load_ok) begin
        presc    <= '0;
        cur_time <= load_time;
      end else if (tick) begin
        presc    <= '0;
        cur_time <= time_next_second(cur_time);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    alarm_slot #(
      .RING_SEC     (RING_SEC)
`ifdef MULTI_ALARM_SNOOZE_EN
      ,
      .SNOOZE_MIN   (SNOOZE_MIN)
`endif
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .wr           (set_alarm && alarm_ok && (alarm_sel == SEL_W'(i))),
      .wr_time      (load_time),
      .wr_en        (alarm_en),
      .cur_time     (cur_time),
      .time_changed (time_changed),
      .tick         (tick),
      .ack          (ack),
`ifdef MULTI_ALARM_SNOOZE_EN
      .snooze       (snooze),
`endif
      .ringing      (ringing[i])
    );
  end

endmodule

// File: doc/multi_alarm_clock.md
MULTI_ALARM_CLOCK -- requirements
Module: multi_alarm_clock

Interface
REQ-001 SHALL have parameter CLK_PER_SEC, default 4, clk cycles per second tick (>=2).
REQ-002 SHALL have parameter NUM_ALARMS, default 4, number of independent alarm slots (1..16).
REQ-003 SHALL have parameter SNOOZE_MIN, default 5, snooze offset in minutes (1..59).
REQ-004 SHALL have parameter RING_SEC, default 60, ring timeout in seconds (>=1).
REQ-005 SHALL have port clk input 1, clock; all logic on rising edge.
REQ-006 SHALL have port reset input 1, asynchronous, active-high.
REQ-007 SHALL have port set_time input 1, load hours/minutes/seconds into current time.
REQ-008 SHALL have port set_alarm input 1, write slot alarm_sel.
REQ-009 SHALL have port alarm_sel input $clog2(NUM_ALARMS) (min 1), target slot.
REQ-010 SHALL have port alarm_en input 1, enable bit written with set_alarm.
REQ-011 SHALL have ports hours input 5, minutes input 6, seconds input 6, load values.
REQ-012 SHALL have port ack input 1, dismiss all ringing/snoozed slots.
REQ-013 SHALL have port snooze input 1, snooze all ringing slots.
REQ-014 SHALL have ports cur_hours output 5, cur_minutes output 6, cur_seconds output 6, current time.
REQ-015 SHALL have port tick output 1, one-cycle pulse when the time advances.
REQ-016 SHALL have port ringing output NUM_ALARMS, per-slot ringing flags; alarm output 1 = OR of ringing.

Function
REQ-017 Prescaler SHALL count 0..CLK_PER_SEC-1; tick asserts in the cycle count==CLK_PER_SEC-1; time increments on that edge.
REQ-018 Time SHALL wrap seconds 59->0 (minute carry), minutes 59->0 (hour carry), hours 23->0.
REQ-019 set_time SHALL load only if hours<=23, minutes<=59, seconds<=59; invalid loads ignored entirely; valid load clears prescaler and overrides a coincident tick (tick still pulses, no increment).
REQ-020 set_alarm SHALL accept same range rule (seconds field stored); valid write sets slot time/enable and forces slot to IDLE.
REQ-021 Each slot SHALL run FSM IDLE, RINGING, SNOOZED.
REQ-022 Match SHALL be evaluated one cycle after any current-time change (increment or valid set_time); ringing rises exactly one clk after cur_* equals slot time.
REQ-023 IDLE->RINGING on enabled match; ring counter loaded with RING_SEC.
REQ-024 RINGING->IDLE on ack, or when ring counter reaches 0 (decrements per tick).
REQ-025 RINGING->SNOOZED on snooze (ack has priority); snooze target = current time + SNOOZE_MIN minutes, wrapping through 23:59 -> 00:xx, seconds kept.
REQ-026 SNOOZED->RINGING on match with snooze target (enable ignored); SNOOZED->IDLE on ack.
REQ-027 set_alarm to slot X SHALL not affect other slots; set_time and set_alarm in the same cycle SHALL both take effect.
REQ-028 Multiple slots matching simultaneously SHALL all ring; ack/snooze act on every eligible slot in that cycle.

Reset
REQ-029 On reset: time 00:00:00, prescaler 0, tick 0, all slots time 0 and disabled, FSMs IDLE, ringing 0, alarm 0.
REQ-030 Reset mid-ring or mid-snooze SHALL abort to reset state with no residual ringing after deassertion.

Configuration
REQ-031 Macro MULTI_ALARM_SNOOZE_EN defined: snooze behaviour per REQ-025/026.
REQ-032 Macro undefined: snooze input ignored, SNOOZED state and snooze-target registers absent, SNOOZE_MIN unused.

Structure
REQ-033 Package clock_pkg SHALL hold slot-state enum, HOURS_MAX=23, MINSEC_MAX=59, time struct (h,m,s) and time add-minutes function.
REQ-034 Sub-module alarm_slot SHALL hold one slot (registers, FSM, ring counter, snooze target), generated NUM_ALARMS times.

Verification (CLK_PER_SEC=4, NUM_ALARMS=4, SNOOZE_MIN=5, RING_SEC=60)
REQ-035 set_time 23:59:59, run 4 clks -> tick pulses once, time 00:00:00.
REQ-036 set_time 24:00:00 or 12:60:00 -> time unchanged, prescaler not cleared.
REQ-037 slot 2 = 07:00:00 enabled, time 06:59:59 -> ringing=4'b0100 one clk after 07:00:00; no ack -> clears after 60 ticks.
REQ-038 Slots 0 and 1 both 08:00:00 -> ringing=4'b0011; ack -> 4'b0000 next cycle.
REQ-039 Ringing at 23:58:10, snooze -> SNOOZED, target 00:03:10, rings one clk after 00:03:10 (SNOOZE_EN); without macro, snooze ignored.
REQ-040 Reset asserted while ringing -> all outputs zero immediately, no ring after release.
